// File: rtl/sram_like_bridge.sv
// sram_like_bridge
//   Bridges a single-cycle CPU SRAM port (en/wen/addr/wdata) onto an
//   SRAM-like bus (req/addr_ok/data_ok). It stalls the pipeline until the bus
//   response arrives and holds the returned data while the global pipeline
//   stall is asserted. On a flush, bus responses that belong to cancelled
//   transactions are counted and discarded in issue order.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   sram_en/wen/addr/wdata   CPU request (wen all-zero = read)
//   sram_rdata        load/fetch data, valid once stall drops after a request
//   stall             combinational pipeline stall
//   flush             cancel the current transaction
//   longest_stall     global stall; freezes a completed result
//   req/wr/size/addr/wdata   registered bus request outputs
//   addr_ok/data_ok/rdata    bus handshake and read data
module sram_like_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DROP_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sram_en,
  input  logic [DATA_W/8-1:0]   sram_wen,
  input  logic [ADDR_W-1:0]     sram_addr,
  input  logic [DATA_W-1:0]     sram_wdata,
  output logic [DATA_W-1:0]     sram_rdata,
  output logic                  stall,
  input  logic                  flush,
  input  logic                  longest_stall,
  output logic                  req,
  output logic                  wr,
  output logic [1:0]            size,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  input  logic                  addr_ok,
  input  logic                  data_ok,
  input  logic [DATA_W-1:0]     rdata
);

  localparam int unsigned      BYTES     = DATA_W / 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  localparam logic [1:0]       FULL_SIZE = 2'($clog2(BYTES));

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

  state_t            state;
  logic [DROP_W-1:0] drop_cnt;

  int unsigned wen_ones;
  logic [1:0]  wr_size;
  logic        dok_cur;
  logic        drop_inc;
  logic        drop_dec;
  logic        issue;

  // Store size is log2 of the number of enabled bytes.
  always_comb begin
    wen_ones = 0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      wen_ones = wen_ones + 32'(sram_wen[i]);
    end
    wr_size = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (wen_ones == (32'd1 << k)) wr_size = 2'(k);
    end
  end

  // A response with drops pending belongs to an older, cancelled transaction.
  // With none pending it completes the live one, so a flush arriving in the
  // same cycle has nothing left to cancel and must not bump the counter.
  always_comb begin
    drop_dec = data_ok && (drop_cnt != '0);
    dok_cur  = data_ok && (drop_cnt == '0);
    drop_inc = flush && !dok_cur &&
               (((state == ADDR) && addr_ok) || (state == WAIT));
    issue    = (state == IDLE) && sram_en && !flush && (drop_cnt != DROP_MAX);
  end

  assign stall = !flush &&
                 ((sram_en && (state == IDLE)) || (state == ADDR) || (state == WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      drop_cnt   <= '0;
      req        <= 1'b0;
      wr         <= 1'b0;
      size       <= '0;
      addr       <= '0;
      wdata      <= '0;
      sram_rdata <= '0;
    end else begin
      if (drop_inc && !drop_dec) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end else if (drop_dec && !drop_inc) begin
        drop_cnt <= drop_cnt - DROP_W'(1);
      end

      if (flush) begin
        state <= IDLE;
        req   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (issue) begin
              req   <= 1'b1;
              wr    <= |sram_wen;
              size  <= (|sram_wen) ? wr_size : FULL_SIZE;
              addr  <= sram_addr;
              wdata <= sram_wdata;
              state <= ADDR;
            end
          end
          ADDR: begin
            if (addr_ok) begin
              req <= 1'b0;
              if (dok_cur) begin
                if (!wr) sram_rdata <= rdata;
                state <= DONE;
              end else begin
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (dok_cur) begin
              if (!wr) sram_rdata <= rdata;
              state <= DONE;
            end
          end
          DONE: begin
            if (!longest_stall) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_like_bridge.sv
// tb_sram_like_bridge
//   Self-checking bench for sram_like_bridge (32-bit data, 2-bit drop counter).
//   A transaction-level reference model tracks outstanding bus responses as an
//   ordered queue of live/cancelled entries and predicts every output each
//   cycle; directed sequences and a table add fixed expected values.
module tb_sram_like_bridge;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned DROP_W = 2;
  localparam int          MAXD   = (1 << DROP_W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sram_en;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          stall;
  logic          flush;
  logic          longest_stall;
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  sram_like_bridge #(.ADDR_W(AW), .DATA_W(DW), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .stall(stall), .flush(flush), .longest_stall(longest_stall),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // q: accepted bus transactions awaiting data_ok, oldest first; 1 = cancelled.
  bit          q[$];
  bit          m_busy = 1'b0;   // request presented, not yet accepted
  bit          m_done = 1'b0;   // result delivered, held under global stall
  logic        m_req = 1'b0, m_wr = 1'b0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  function automatic bit live_out();
    foreach (q[i]) if (!q[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int killed_cnt();
    int n = 0;
    foreach (q[i]) if (q[i]) n++;
    return n;
  endfunction

  function automatic bit model_idle();
    return !m_busy && !live_out() && !m_done;
  endfunction

  task automatic model_edge();
    bit was_idle;
    bit completed;
    int kc;
    was_idle  = model_idle();
    kc        = killed_cnt();
    completed = 1'b0;
    if (m_busy && addr_ok) begin
      q.push_back(1'b0);
      m_busy = 1'b0;
      m_req  = 1'b0;
    end
    if (data_ok && q.size() > 0) begin
      completed = (q[0] == 1'b0);
      void'(q.pop_front());
    end
    if (flush) begin
      m_busy = 1'b0;
      m_req  = 1'b0;
      m_done = 1'b0;
      foreach (q[i]) q[i] = 1'b1;
    end else if (completed) begin
      if (!m_wr) m_rdata = rdata;
      m_done = 1'b1;
    end else if (m_done) begin
      if (!longest_stall) m_done = 1'b0;
    end else if (was_idle && sram_en && kc != MAXD) begin
      m_busy  = 1'b1;
      m_req   = 1'b1;
      m_wr    = |sram_wen;
      m_size  = m_wr ? 2'($clog2($countones(sram_wen))) : 2'd2;
      m_addr  = sram_addr;
      m_wdata = sram_wdata;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_busy = 1'b0; m_done = 1'b0;
      m_req = 1'b0; m_wr = 1'b0; m_size = '0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      model_edge();
    end
  end

  task automatic compare_all();
    logic exp_stall;
    exp_stall = !flush && ((model_idle() && sram_en) || m_busy || live_out());
    chk("m_req",   req,        m_req);
    chk("m_wr",    wr,         m_wr);
    chk("m_size",  size,       m_size);
    chk("m_addr",  addr,       m_addr);
    chk("m_wdata", wdata,      m_wdata);
    chk("m_rdata", sram_rdata, m_rdata);
    chk("m_stall", stall,      exp_stall);
  endtask

  // Check on the falling edge, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    sram_en = 1'b0; sram_wen = '0; sram_addr = '0; sram_wdata = '0;
    flush = 1'b0; longest_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
  endtask

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'b0000, 32'h0000_0100, 32'h0,         32'hA5A5_0001, 1'b0, 2'd2, 32'hA5A5_0001};
    vecs[1] = '{4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'hBAD0_0001, 1'b1, 2'd0, 32'hA5A5_0001};
    vecs[2] = '{4'b0001, 32'h0000_2000, 32'h0000_00CD, 32'hBAD0_0002, 1'b1, 2'd0, 32'hA5A5_0001};
    vecs[3] = '{4'b1000, 32'h0000_2003, 32'hEF00_0000, 32'hBAD0_0003, 1'b1, 2'd0, 32'hA5A5_0001};
    vecs[4] = '{4'b0011, 32'h0000_2000, 32'h0000_1234, 32'hBAD0_0004, 1'b1, 2'd1, 32'hA5A5_0001};
    vecs[5] = '{4'b1100, 32'h0000_2002, 32'h5678_0000, 32'hBAD0_0005, 1'b1, 2'd1, 32'hA5A5_0001};
    vecs[6] = '{4'b1111, 32'h0000_2004, 32'hCAFE_F00D, 32'hBAD0_0006, 1'b1, 2'd2, 32'hA5A5_0001};
    vecs[7] = '{4'b0000, 32'h0000_3FFC, 32'h0,         32'h0F0F_1234, 1'b0, 2'd2, 32'h0F0F_1234};

    quiet();
    rst = 1'b1;
    step();
    step();
    // reset state
    chk("rst_req",   req, 0);
    chk("rst_wr",    wr, 0);
    chk("rst_size",  size, 0);
    chk("rst_addr",  addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rdata", sram_rdata, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    step();

    // basic read with delayed handshakes
    sram_en = 1'b1; sram_wen = '0; sram_addr = 32'h1000;
    #1 chk("rd_stall_idle", stall, 1);
    step();
    chk("rd_req", req, 1);
    chk("rd_size", size, 2);
    chk("rd_addr", addr, 32'h1000);
    chk("rd_wr", wr, 0);
    step();
    chk("rd_req_hold", req, 1);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    chk("rd_req_drop", req, 0);
    chk("rd_stall_wait", stall, 1);
    step();
    data_ok = 1'b1; rdata = 32'hDEAD_BEEF; step(); data_ok = 1'b0;
    chk("rd_stall_done", stall, 0);
    chk("rd_data", sram_rdata, 32'hDEAD_BEEF);
    sram_en = 1'b0; step();

    // table: size encoding and write data handling
    for (int v = 0; v < 8; v++) begin
      sram_en = 1'b1; sram_wen = vecs[v].wen; sram_addr = vecs[v].a; sram_wdata = vecs[v].wd;
      step();
      chk("tbl_req",   req,   1);
      chk("tbl_wr",    wr,    vecs[v].exp_wr);
      chk("tbl_size",  size,  vecs[v].exp_size);
      chk("tbl_addr",  addr,  vecs[v].a);
      chk("tbl_wdata", wdata, vecs[v].wd);
      addr_ok = 1'b1; step(); addr_ok = 1'b0;
      data_ok = 1'b1; rdata = vecs[v].rd; step(); data_ok = 1'b0;
      chk("tbl_stall", stall, 0);
      chk("tbl_rdata", sram_rdata, vecs[v].exp_rdata);
      sram_en = 1'b0; sram_wen = '0; step();
    end

    // hold under global stall
    sram_en = 1'b1; sram_addr = 32'h400; step();
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    longest_stall = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678; step(); data_ok = 1'b0;
    chk("hold_data0", sram_rdata, 32'h1234_5678);
    chk("hold_stall", stall, 0);
    sram_addr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_data", sram_rdata, 32'h1234_5678);
      chk("hold_noreq", req, 0);
    end
    longest_stall = 1'b0; step();
    chk("hold_idle_noreq", req, 0);
    step();
    chk("hold_new_req", req, 1);
    chk("hold_new_addr", addr, 32'h500);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h55; step(); data_ok = 1'b0;
    sram_en = 1'b0; step();

    // flush in WAIT, then a new read: first response is discarded
    sram_en = 1'b1; sram_addr = 32'h5000; step();
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    flush = 1'b1;
    #1 chk("fw_stall_flush", stall, 0);
    step(); flush = 1'b0;
    sram_addr = 32'h3000; step();
    chk("fw_req", req, 1);
    chk("fw_addr", addr, 32'h3000);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h1111; step();
    chk("fw_drop_stall", stall, 1);
    chk("fw_drop_keep", sram_rdata, 32'h55);
    rdata = 32'h2222; step(); data_ok = 1'b0;
    chk("fw_deliver_stall", stall, 0);
    chk("fw_deliver", sram_rdata, 32'h2222);
    sram_en = 1'b0; step();

    // flush in ADDR without addr_ok: nothing counted
    sram_en = 1'b1; sram_addr = 32'h6000; step();
    chk("fa_req", req, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fa_req_low", req, 0);
    sram_addr = 32'h6004; step();
    chk("fa_new_req", req, 1);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h6666; step(); data_ok = 1'b0;
    chk("fa_first_dok", sram_rdata, 32'h6666);
    chk("fa_stall", stall, 0);
    sram_en = 1'b0; step();

    // drop counter saturation
    for (int k = 0; k < MAXD; k++) begin
      sram_en = 1'b1; sram_addr = 32'h7100 + 32'(k * 4); step();
      addr_ok = 1'b1; step(); addr_ok = 1'b0;
      flush = 1'b1; step(); flush = 1'b0;
    end
    sram_addr = 32'h7000;
    #1 chk("sat_stall", stall, 1);
    step();
    chk("sat_noreq0", req, 0);
    chk("sat_stall0", stall, 1);
    step();
    chk("sat_noreq1", req, 0);
    data_ok = 1'b1; rdata = 32'hD0D0_0001; step(); data_ok = 1'b0;
    chk("sat_noreq2", req, 0);
    step();
    chk("sat_issue", req, 1);
    chk("sat_addr", addr, 32'h7000);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'hD0D0_0002; step();
    rdata = 32'hD0D0_0003; step();
    chk("sat_drain_stall", stall, 1);
    rdata = 32'h7777; step(); data_ok = 1'b0;
    chk("sat_deliver", sram_rdata, 32'h7777);
    sram_en = 1'b0; step();

    // reset in the middle of a transaction
    sram_en = 1'b1; sram_addr = 32'h8000; step();
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    rst = 1'b1; sram_en = 1'b0;
    #1;
    chk("mrst_req", req, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_rdata", sram_rdata, 0);
    step(); rst = 1'b0; step();
    sram_en = 1'b1; sram_addr = 32'h8004; step();
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h8888; step(); data_ok = 1'b0;
    chk("mrst_after", sram_rdata, 32'h8888);
    sram_en = 1'b0; step();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      flush         = ($urandom_range(0, 19) == 0);
      longest_stall = ($urandom_range(0, 3) == 0);
      sram_en       = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        2:       sram_wen = 4'b0001 << $urandom_range(0, 3);
        3:       sram_wen = 4'b0011 << (2 * $urandom_range(0, 1));
        4:       sram_wen = 4'b1111;
        default: sram_wen = 4'b0000;
      endcase
      sram_addr  = $urandom;
      sram_wdata = $urandom;
      addr_ok    = m_busy && ($urandom_range(0, 1) == 1);
      data_ok    = ((q.size() > 0) || addr_ok) && ($urandom_range(0, 2) == 0);
      rdata      = $urandom;
      step();
    end

    quiet();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
